pipe_perf_monitor: RTL and testbench
====================================

Name: pipe_perf_monitor

Overview:
Sequential monitor inside the pipelined CPU, next to the IF-stage hazard logic. It consumes the IF stall/flush strobes, retire strobe and PC, and keeps saturating cycle, stall, flush and retire counters. It also provides snapshot registers, a cycle-budget halt and a stuck-PC detector. The benches read it instead of keeping their own stall/flush tallies.

Parameters:
CNT_W, 32, width of every counter and snapshot register
MAX_CYCLES, 30, RUN cycles counted before entering DONE (must be ≥1)
STUCK_LIMIT, 8, consecutive non-stalled RUN cycles with unchanged PC that raise stuck_o (≥2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  CPU start level; sampled each cycle
stall_i  in  1  IF stall strobe (IF_stall_signal)
flush_i  in  1  IF flush strobe (IF_flush_signal)
retire_i  in  1  one instruction completed WB this cycle
pc_i  in  32  current PC (PC.pc_o)
clear_i  in  1  zero counters/flags, return to IDLE
snapshot_i  in  1  copy live counters into snapshot registers
cycle_cnt_o  out  CNT_W  live RUN-cycle count
stall_cnt_o  out  CNT_W  live stall count
flush_cnt_o  out  CNT_W  live flush count
retire_cnt_o  out  CNT_W  live retire count
snap_cycle_o, snap_stall_o, snap_flush_o, snap_retire_o  out  CNT_W each  snapshot copies
running_o  out  1  state==RUN
halt_o  out  1  state==DONE
stuck_o  out  1  sticky stuck-PC flag

Behaviour:
- Reset: clock and reset are fixed as one clock, clk_i, and reset rst_i, synchronous and active-high. When rst_i is high at a rising edge: state=IDLE; all counters, snapshots, stuck_o, same-PC counter and prev-PC-valid cleared. running_o=0, halt_o=0. rst_i overrides every other input. Reset in the middle of RUN behaves identically.
- States: IDLE, RUN, DONE. All outputs are registered; an event sampled at edge N is visible after edge N.
- IDLE: no counting. Goes to RUN at the edge where start_i=1. That edge does not count as a RUN cycle.
- RUN, counting at each edge:
  - cycle_cnt +1.
  - stall_cnt +1 if stall_i; flush_cnt +1 if flush_i; retire_cnt +1 if retire_i.
  - Simultaneous events are all counted independently.
- RUN exits:
  - Goes to DONE at the edge where cycle_cnt reaches MAX_CYCLES; the events of that last cycle are still counted.
  - start_i=0 in RUN: goes to IDLE, counters hold. A later start_i=1 resumes counting from the held values.
- DONE: sticky. No counting; all counters frozen. Leaves only via rst_i or clear_i.
- Saturation: every counter stops at 2^CNT_W−1 and never wraps. If cycle_cnt saturates before MAX_CYCLES (only when MAX_CYCLES > 2^CNT_W−1), the state stays RUN.
- clear_i (any state, lower priority than rst_i): same effect as reset. It beats events, snapshot_i and start_i in the same cycle; the next state is IDLE even if start_i=1.
- snapshot_i (when not clearing): snapshot registers take the pre-edge live values, i.e. the values on the *_cnt_o ports that cycle, not including this cycle's increments. Allowed in any state.
- Stuck detector, RUN only:
  - prev_pc is registered every RUN cycle; prev-valid is set after the first RUN cycle.
  - If prev-valid, pc_i==prev_pc and stall_i=0: same_cnt +1 (saturates at STUCK_LIMIT). Otherwise same_cnt=0.
  - Stalled cycles reset same_cnt.
  - stuck_o sets at the edge where same_cnt becomes STUCK_LIMIT. It is sticky until rst_i/clear_i.
  - Leaving RUN clears prev-valid and same_cnt; stuck_o is kept.

Test Plan:
1. Reset, then start_i=1 held with 4 stall pulses and 2 flush pulses (one cycle has both stall_i and flush_i): after 30 RUN edges, cycle_cnt=30, stall_cnt=4, flush_cnt=2, halt_o=1, running_o=0; further stall pulses leave stall_cnt=4.
2. Snapshot at cycle_cnt=10 with stall_i=1 in the same cycle: snap_cycle=10, snap_stall equals the pre-edge value, live stall_cnt increments; live counters keep running.
3. pc_i held at 0x20 with stall_i=0 for 9 RUN cycles: stuck_o rises on the 9th edge (8 repeats). The same sequence with a stall in cycle 5 delays stuck_o accordingly.
4. clear_i together with start_i=1, stall_i=1 in DONE: all counters 0, stuck_o=0, state IDLE next cycle; RUN begins one cycle later.
5. rst_i asserted in the middle of RUN at cycle_cnt=12 while snapshot_i=1: every output 0 after the edge, snapshots 0.
6. CNT_W=4, MAX_CYCLES=40, stall_i held 1: stall_cnt and cycle_cnt stick at 15, no wrap, state stays RUN.

Source files
------------

// File: rtl/pipe_perf_monitor_if.sv
// Handshake-free observation bundle between the IF-stage hazard logic and the perf monitor.
interface pipe_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             stall_i;
  logic             flush_i;
  logic             retire_i;
  logic [31:0]      pc_i;
  logic             clear_i;
  logic             snapshot_i;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] retire_cnt_o;
  logic [CNT_W-1:0] snap_cycle_o;
  logic [CNT_W-1:0] snap_stall_o;
  logic [CNT_W-1:0] snap_flush_o;
  logic [CNT_W-1:0] snap_retire_o;
  logic             running_o;
  logic             halt_o;
  logic             stuck_o;

  modport master (
    output start_i, stall_i, flush_i, retire_i, pc_i, clear_i, snapshot_i,
    input  cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o,
           snap_cycle_o, snap_stall_o, snap_flush_o, snap_retire_o,
           running_o, halt_o, stuck_o
  );

  modport slave (
    input  start_i, stall_i, flush_i, retire_i, pc_i, clear_i, snapshot_i,
    output cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o,
           snap_cycle_o, snap_stall_o, snap_flush_o, snap_retire_o,
           running_o, halt_o, stuck_o
  );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Saturating cycle/stall/flush/retire counters with snapshots, cycle-budget halt and stuck-PC flag.
// All outputs registered: an event sampled at edge N is visible after edge N; no backpressure.
module pipe_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 30,
  parameter int STUCK_LIMIT = 8
) (
  input logic                  clk_i,
  input logic                  rst_i,
  pipe_perf_monitor_if.slave   mon
);

  localparam int SW = $clog2(STUCK_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, retire_cnt;
  logic [CNT_W-1:0] snap_cycle, snap_stall, snap_flush, snap_retire;
  logic [31:0]      prev_pc;
  logic             prev_vld;
  logic [SW-1:0]    same_cnt, same_nxt;
  logic             stuck;
  logic             wipe;
  logic             run_cyc;
  logic             reach_max;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign wipe    = rst_i | mon.clear_i;
  // A RUN cycle only counts while start_i stays high; start_i=0 drops back to IDLE with counters held.
  assign run_cyc = (state == RUN) && mon.start_i;

  // A saturated cycle counter can never reach a budget beyond its range, so RUN persists.
  assign reach_max = (cycle_cnt != '1) &&
                     ((64'(cycle_cnt) + 64'd1) == 64'(MAX_CYCLES));

  always_ff @(posedge clk_i) begin
    if (wipe) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mon.start_i) state_nxt = RUN;
      RUN: begin
        if (!mon.start_i)   state_nxt = IDLE;
        else if (reach_max) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mon.running_o = (state == RUN);
    mon.halt_o    = (state == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (wipe) begin
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else if (run_cyc) begin
      cycle_cnt  <= sat_inc(cycle_cnt,  1'b1);
      stall_cnt  <= sat_inc(stall_cnt,  mon.stall_i);
      flush_cnt  <= sat_inc(flush_cnt,  mon.flush_i);
      retire_cnt <= sat_inc(retire_cnt, mon.retire_i);
    end
  end

  // Snapshots capture the pre-edge live values, excluding this cycle's increments.
  always_ff @(posedge clk_i) begin
    if (wipe) begin
      snap_cycle  <= '0;
      snap_stall  <= '0;
      snap_flush  <= '0;
      snap_retire <= '0;
    end else if (mon.snapshot_i) begin
      snap_cycle  <= cycle_cnt;
      snap_stall  <= stall_cnt;
      snap_flush  <= flush_cnt;
      snap_retire <= retire_cnt;
    end
  end

  always_comb begin
    same_nxt = '0;
    if (prev_vld && (mon.pc_i == prev_pc) && !mon.stall_i) begin
      same_nxt = (same_cnt == SW'(STUCK_LIMIT)) ? same_cnt : same_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wipe) begin
      prev_pc  <= '0;
      prev_vld <= 1'b0;
      same_cnt <= '0;
      stuck    <= 1'b0;
    end else if (run_cyc) begin
      prev_pc  <= mon.pc_i;
      prev_vld <= 1'b1;
      same_cnt <= same_nxt;
      if (same_nxt == SW'(STUCK_LIMIT)) stuck <= 1'b1;
    end else begin
      prev_vld <= 1'b0;
      same_cnt <= '0;
    end
  end

  assign mon.cycle_cnt_o   = cycle_cnt;
  assign mon.stall_cnt_o   = stall_cnt;
  assign mon.flush_cnt_o   = flush_cnt;
  assign mon.retire_cnt_o  = retire_cnt;
  assign mon.snap_cycle_o  = snap_cycle;
  assign mon.snap_stall_o  = snap_stall;
  assign mon.snap_flush_o  = snap_flush;
  assign mon.snap_retire_o = snap_retire;
  assign mon.stuck_o       = stuck;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: default instance plus a 4-bit saturation instance.
module tb_pipe_perf_monitor;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_perf_monitor_if #(.CNT_W(32)) mon ();
  pipe_perf_monitor_if #(.CNT_W(4))  sat ();

  pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(30), .STUCK_LIMIT(8)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .mon   (mon)
  );

  pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLES(40), .STUCK_LIMIT(8)) u_sat (
    .clk_i (clk),
    .rst_i (rst),
    .mon   (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mon.start_i = 0; mon.stall_i = 0; mon.flush_i = 0; mon.retire_i = 0;
    mon.pc_i = 32'h0; mon.clear_i = 0; mon.snapshot_i = 0;
    sat.start_i = 0; sat.stall_i = 0; sat.flush_i = 0; sat.retire_i = 0;
    sat.pc_i = 32'h0; sat.clear_i = 0; sat.snapshot_i = 0;
    tick();
    tick();

    check("rst_cycle",   64'(mon.cycle_cnt_o),  64'd0);
    check("rst_stall",   64'(mon.stall_cnt_o),  64'd0);
    check("rst_running", 64'(mon.running_o),    64'd0);
    check("rst_halt",    64'(mon.halt_o),       64'd0);
    check("rst_stuck",   64'(mon.stuck_o),      64'd0);
    check("rst_snap",    64'(mon.snap_cycle_o), 64'd0);

    rst = 1'b0;
    tick();
    check("idle_running", 64'(mon.running_o), 64'd0);

    // Budget run: stalls at 3,7,11,22; flushes at 7,18; retire on even cycles; snapshot at 11.
    mon.start_i = 1'b1;
    tick();
    check("start_running", 64'(mon.running_o),   64'd1);
    check("start_cycle0",  64'(mon.cycle_cnt_o), 64'd0);
    for (int c = 1; c <= 30; c++) begin
      mon.stall_i    = (c == 3) || (c == 7) || (c == 11) || (c == 22);
      mon.flush_i    = (c == 7) || (c == 18);
      mon.retire_i   = (c % 2 == 0);
      mon.pc_i       = 32'(c * 4);
      mon.snapshot_i = (c == 11);
      tick();
      if (c == 11) begin
        check("snap_cycle",  64'(mon.snap_cycle_o),  64'd10);
        check("snap_stall",  64'(mon.snap_stall_o),  64'd2);
        check("snap_flush",  64'(mon.snap_flush_o),  64'd1);
        check("snap_retire", 64'(mon.snap_retire_o), 64'd5);
        check("live_stall11", 64'(mon.stall_cnt_o),  64'd3);
        check("live_cycle11", 64'(mon.cycle_cnt_o),  64'd11);
      end
      if (c == 29) begin
        check("c29_running", 64'(mon.running_o), 64'd1);
        check("c29_halt",    64'(mon.halt_o),    64'd0);
      end
    end
    mon.stall_i = 0; mon.flush_i = 0; mon.retire_i = 0; mon.snapshot_i = 0;
    check("done_cycle",   64'(mon.cycle_cnt_o),  64'd30);
    check("done_stall",   64'(mon.stall_cnt_o),  64'd4);
    check("done_flush",   64'(mon.flush_cnt_o),  64'd2);
    check("done_retire",  64'(mon.retire_cnt_o), 64'd15);
    check("done_halt",    64'(mon.halt_o),       64'd1);
    check("done_running", 64'(mon.running_o),    64'd0);
    for (int i = 0; i < 3; i++) begin
      mon.stall_i = 1'b1;
      tick();
      mon.stall_i = 1'b0;
      tick();
    end
    check("frozen_stall", 64'(mon.stall_cnt_o),  64'd4);
    check("frozen_cycle", 64'(mon.cycle_cnt_o),  64'd30);
    check("frozen_halt",  64'(mon.halt_o),       64'd1);
    check("held_snap",    64'(mon.snap_cycle_o), 64'd10);

    // Clear in DONE beats start and stall.
    mon.clear_i = 1'b1; mon.stall_i = 1'b1;
    tick();
    mon.clear_i = 1'b0; mon.stall_i = 1'b0;
    check("clr_cycle",   64'(mon.cycle_cnt_o),  64'd0);
    check("clr_stall",   64'(mon.stall_cnt_o),  64'd0);
    check("clr_flush",   64'(mon.flush_cnt_o),  64'd0);
    check("clr_retire",  64'(mon.retire_cnt_o), 64'd0);
    check("clr_snap",    64'(mon.snap_cycle_o), 64'd0);
    check("clr_halt",    64'(mon.halt_o),       64'd0);
    check("clr_running", 64'(mon.running_o),    64'd0);
    tick();
    check("clr_resume_running", 64'(mon.running_o),   64'd1);
    check("clr_resume_cycle",   64'(mon.cycle_cnt_o), 64'd0);

    // Stuck PC without stalls: 9 RUN cycles at 0x20.
    for (int c = 1; c <= 9; c++) begin
      mon.pc_i = 32'h20;
      tick();
      if (c == 8) check("stuck_edge8", 64'(mon.stuck_o), 64'd0);
      if (c == 9) check("stuck_edge9", 64'(mon.stuck_o), 64'd1);
    end
    mon.pc_i = 32'h24;
    tick();
    check("stuck_sticky", 64'(mon.stuck_o), 64'd1);

    mon.clear_i = 1'b1;
    tick();
    mon.clear_i = 1'b0;
    check("clr_run_stuck",   64'(mon.stuck_o),     64'd0);
    check("clr_run_running", 64'(mon.running_o),   64'd0);
    check("clr_run_cycle",   64'(mon.cycle_cnt_o), 64'd0);
    tick();

    // Same PC with a stall in cycle 5 pushes the flag out to edge 13.
    for (int c = 1; c <= 13; c++) begin
      mon.pc_i    = 32'h20;
      mon.stall_i = (c == 5);
      tick();
      if (c == 12) check("stall_stuck_edge12", 64'(mon.stuck_o), 64'd0);
      if (c == 13) check("stall_stuck_edge13", 64'(mon.stuck_o), 64'd1);
    end
    mon.stall_i = 1'b0;
    check("stall_stuck_cnt", 64'(mon.stall_cnt_o), 64'd1);

    // Reset mid-RUN at cycle 12 with a simultaneous snapshot request.
    mon.clear_i = 1'b1;
    tick();
    mon.clear_i = 1'b0;
    tick();
    for (int c = 1; c <= 12; c++) begin
      mon.pc_i    = 32'(c * 8);
      mon.stall_i = 1'b1;
      tick();
    end
    mon.stall_i = 1'b0;
    check("pre_rst_cycle", 64'(mon.cycle_cnt_o), 64'd12);
    check("pre_rst_stall", 64'(mon.stall_cnt_o), 64'd12);
    rst = 1'b1; mon.snapshot_i = 1'b1;
    tick();
    rst = 1'b0; mon.snapshot_i = 1'b0; mon.start_i = 1'b0;
    check("mid_rst_cycle",    64'(mon.cycle_cnt_o),  64'd0);
    check("mid_rst_stall",    64'(mon.stall_cnt_o),  64'd0);
    check("mid_rst_snap_cyc", 64'(mon.snap_cycle_o), 64'd0);
    check("mid_rst_snap_stl", 64'(mon.snap_stall_o), 64'd0);
    check("mid_rst_running",  64'(mon.running_o),    64'd0);
    check("mid_rst_halt",     64'(mon.halt_o),       64'd0);
    check("mid_rst_stuck",    64'(mon.stuck_o),      64'd0);

    // 4-bit counters saturate at 15 long before the 40-cycle budget.
    sat.start_i = 1'b1;
    tick();
    sat.stall_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      sat.pc_i = 32'(i * 4);
      tick();
      if (i == 15) check("sat_cycle15", 64'(sat.cycle_cnt_o), 64'd15);
    end
    check("sat_cycle",   64'(sat.cycle_cnt_o), 64'd15);
    check("sat_stall",   64'(sat.stall_cnt_o), 64'd15);
    check("sat_running", 64'(sat.running_o),   64'd1);
    check("sat_halt",    64'(sat.halt_o),      64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
